// File: rtl/armleocpu_mem_nr1w.sv
// Multi-read-port, single-write-port synchronous memory with optional
// write-to-read bypass and an optional post-reset zeroing sweep.
module armleocpu_mem_nr1w #(
   parameter int unsigned DEPTH_LOG2     = 5,
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned READ_PORTS     = 2,
   parameter int unsigned BYPASS         = 1,
   parameter int unsigned CLEAR_ON_RESET = 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [READ_PORTS*DEPTH_LOG2-1:0] read_addr,
   input  logic [READ_PORTS-1:0]            read,
   output logic [READ_PORTS*WIDTH-1:0]      read_data,
   input  logic [DEPTH_LOG2-1:0]            write_addr,
   input  logic                             write,
   input  logic [WIDTH-1:0]                 write_data,
   output logic                             ready
);

   localparam int unsigned ELEMENTS = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] LAST_ADDR = DEPTH_LOG2'(ELEMENTS - 1);

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;

   logic [0:0]                      state_q, state_d;
   logic [DEPTH_LOG2-1:0]           clear_cnt_q, clear_cnt_d;
   logic                            ready_q, ready_d;
   logic [READ_PORTS*WIDTH-1:0]     read_data_q, read_data_d;

   logic [WIDTH-1:0]                storage [ELEMENTS];

   logic                            mem_we_c;
   logic [DEPTH_LOG2-1:0]           mem_waddr_c;
   logic [WIDTH-1:0]                mem_wdata_c;

   // Next-state, storage write port and per-port read data selection
   always_comb begin
      state_d     = state_q;
      clear_cnt_d = clear_cnt_q;
      read_data_d = read_data_q;
      mem_we_c    = 1'b0;
      mem_waddr_c = write_addr;
      mem_wdata_c = write_data;

      case (state_q)
         ST_CLEAR: begin
            if (CLEAR_ON_RESET != 0) begin
               mem_we_c    = 1'b1;
               mem_waddr_c = clear_cnt_q;
               mem_wdata_c = '0;
               clear_cnt_d = DEPTH_LOG2'(clear_cnt_q + DEPTH_LOG2'(1));
               if (clear_cnt_q == LAST_ADDR) begin
                  state_d = ST_READY;
               end
            end else begin
               state_d = ST_READY;
            end
         end
         default: begin
            mem_we_c = write;
            // Storage is read before this edge's write lands, so the
            // non-bypass path naturally returns the old contents.
            for (int p = 0; p < int'(READ_PORTS); p++) begin
               if (read[p]) begin
                  if ((BYPASS != 0) && write &&
                      (read_addr[p*DEPTH_LOG2 +: DEPTH_LOG2] == write_addr)) begin
                     read_data_d[p*WIDTH +: WIDTH] = write_data;
                  end else begin
                     read_data_d[p*WIDTH +: WIDTH] =
                        storage[read_addr[p*DEPTH_LOG2 +: DEPTH_LOG2]];
                  end
               end
            end
         end
      endcase

      ready_d = (state_d == ST_READY);
   end

   // Control and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_CLEAR;
         clear_cnt_q <= '0;
         ready_q     <= 1'b0;
         read_data_q <= '0;
      end else begin
         state_q     <= state_d;
         clear_cnt_q <= clear_cnt_d;
         ready_q     <= ready_d;
         read_data_q <= read_data_d;
      end
   end

   // Storage array, intentionally without reset
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         storage[mem_waddr_c] <= mem_wdata_c;
      end
   end

   assign read_data = read_data_q;
   assign ready     = ready_q;

endmodule

// File: tb/tb_armleocpu_mem_nr1w.sv
// Directed bench for armleocpu_mem_nr1w: bypass, non-bypass and no-sweep
// instances share one stimulus stream.
module tb_armleocpu_mem_nr1w;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  read_addr;
   logic [1:0]  read;
   logic [4:0]  write_addr;
   logic        write;
   logic [31:0] write_data;

   logic [63:0] rdata_b, rdata_n, rdata_c;
   logic        ready_b, ready_n, ready_c;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   armleocpu_mem_nr1w #(.BYPASS(1), .CLEAR_ON_RESET(1)) u_byp (
      .clk(clk), .rst_n(rst_n), .read_addr(read_addr), .read(read),
      .read_data(rdata_b), .write_addr(write_addr), .write(write),
      .write_data(write_data), .ready(ready_b));

   armleocpu_mem_nr1w #(.BYPASS(0), .CLEAR_ON_RESET(1)) u_nob (
      .clk(clk), .rst_n(rst_n), .read_addr(read_addr), .read(read),
      .read_data(rdata_n), .write_addr(write_addr), .write(write),
      .write_data(write_data), .ready(ready_n));

   armleocpu_mem_nr1w #(.BYPASS(1), .CLEAR_ON_RESET(0)) u_ncl (
      .clk(clk), .rst_n(rst_n), .read_addr(read_addr), .read(read),
      .read_data(rdata_c), .write_addr(write_addr), .write(write),
      .write_data(write_data), .ready(ready_c));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1);
      read      = en;
      read_addr = {a1, a0};
   endtask

   task automatic set_wr(input logic en, input logic [4:0] a, input logic [31:0] d);
      write      = en;
      write_addr = a;
      write_data = d;
   endtask

   // Waits for ready on the sweeping instances; returns edges counted
   task automatic wait_ready(output int edges);
      edges = 0;
      while (!(ready_b && ready_n) && edges < 100) begin
         tick();
         edges++;
      end
   endtask

   initial begin
      int edges;
      int nz;

      rst_n = 1'b0;
      set_rd(2'b00, 5'd0, 5'd0);
      set_wr(1'b0, 5'd0, 32'h0);
      #23;
      check("reset_ready", 64'(ready_b), 64'd0);
      check("reset_rdata", rdata_b, 64'd0);

      // Release reset away from an edge; hammer writes/reads during the sweep
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      set_wr(1'b1, 5'd3, 32'hFFFF_FFFF);
      set_rd(2'b11, 5'd3, 5'd3);
      edges = 0;
      nz = 0;
      while (!(ready_b && ready_n) && edges < 100) begin
         tick();
         edges++;
         if (edges == 1) check("noclear_ready_1edge", 64'(ready_c), 64'd1);
         if (rdata_b != 64'd0 || rdata_n != 64'd0) nz++;
      end
      set_wr(1'b0, 5'd0, 32'h0);
      set_rd(2'b00, 5'd0, 5'd0);
      check("sweep_edges", 64'(edges), 64'd32);
      check("sweep_ready_nob", 64'(ready_n), 64'd1);
      check("sweep_rdata_held0", 64'(nz), 64'd0);

      set_rd(2'b11, 5'd0, 5'd17);
      tick();
      check("clr_rd_0_17", rdata_b, 64'd0);
      set_rd(2'b11, 5'd31, 5'd3);
      tick();
      check("clr_rd_31_3", rdata_b, 64'd0);
      check("clr_rd_31_3_nob", rdata_n, 64'd0);

      // Basic write / read
      set_rd(2'b00, 5'd0, 5'd0);
      set_wr(1'b1, 5'd5, 32'hDEAD_BEEF);
      tick();
      set_wr(1'b1, 5'd6, 32'h1234_5678);
      tick();
      set_wr(1'b0, 5'd0, 32'h0);
      set_rd(2'b11, 5'd5, 5'd6);
      tick();
      check("basic_rd", rdata_b, {32'h1234_5678, 32'hDEAD_BEEF});
      check("basic_rd_nob", rdata_n, {32'h1234_5678, 32'hDEAD_BEEF});

      // Collision on address 9 from both ports
      set_rd(2'b00, 5'd0, 5'd0);
      set_wr(1'b1, 5'd9, 32'h1111_1111);
      tick();
      set_wr(1'b1, 5'd9, 32'h2222_2222);
      set_rd(2'b11, 5'd9, 5'd9);
      tick();
      check("coll_bypass", rdata_b, {2{32'h2222_2222}});
      check("coll_nobypass", rdata_n, {2{32'h1111_1111}});
      set_wr(1'b0, 5'd0, 32'h0);
      tick();
      check("coll_after_nob", rdata_n, {2{32'h2222_2222}});

      // Hold: port 0 disabled while its address is overwritten
      set_rd(2'b11, 5'd5, 5'd6);
      tick();
      check("hold_pre", rdata_b, {32'h1234_5678, 32'hDEAD_BEEF});
      set_rd(2'b10, 5'd5, 5'd6);
      set_wr(1'b1, 5'd5, 32'hCAFE_F00D);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_port0", 64'(rdata_b[31:0]), 64'(32'hDEAD_BEEF));
         check("hold_port0_nob", 64'(rdata_n[31:0]), 64'(32'hDEAD_BEEF));
      end
      set_wr(1'b0, 5'd0, 32'h0);
      set_rd(2'b01, 5'd5, 5'd6);
      tick();
      check("hold_release", 64'(rdata_b[31:0]), 64'(32'hCAFE_F00D));

      // Asynchronous reset while ready with non-zero read data
      set_rd(2'b00, 5'd0, 5'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_ready", 64'(ready_b), 64'd0);
      check("async_rst_rdata", rdata_b, 64'd0);
      tick();
      rst_n = 1'b1;

      // Abort the sweep at cycle 10, then it must run a full 32 edges again
      for (int i = 0; i < 10; i++) tick();
      check("midsweep_not_ready", 64'(ready_b), 64'd0);
      rst_n = 1'b0;
      #1;
      check("midsweep_rst_ready", 64'(ready_b | ready_n), 64'd0);
      check("midsweep_rst_rdata", rdata_b | rdata_n, 64'd0);
      #1;
      rst_n = 1'b1;
      wait_ready(edges);
      check("resweep_edges", 64'(edges), 64'd32);

      set_rd(2'b11, 5'd5, 5'd9);
      tick();
      check("resweep_cleared", rdata_b, 64'd0);
      check("resweep_cleared_nob", rdata_n, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
